// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer and a bounded hold time.
// Every grant is followed by one idle bubble cycle before the next arbitration.
module rr_ring_arbiter #(
  parameter  int WIDTH    = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDXW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic [IDXW-1:0]  grant_idx,
  output logic             busy,
  output logic             timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             to_q, to_d;

  logic [IDXW-1:0]  pidx;
  logic [IDXW-1:0]  win_idx;
  logic             win_found;
  logic             owner_live;
  logic             others;
  logic             at_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
      grant_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    pidx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (ptr_q[i]) pidx = IDXW'(i);
  end

  // Search starts at the pointer bit and wraps upward.
  always_comb begin : win_search
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      j = (int'(pidx) + i) % WIDTH;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = IDXW'(j);
      end
    end
  end

  always_comb begin
    owner_live = |(req & grant_q);
    others     = |(req & ~grant_q);
    at_limit   = (hold_q == HOLD_LAST);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          idx_d            = win_idx;
          busy_d           = 1'b1;
          hold_d           = '0;
          state_d          = GRANT;
        end
      end
      GRANT: begin
        if (!owner_live || (at_limit && others)) begin
          ptr_d   = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
          grant_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
          to_d    = owner_live;
          state_d = IDLE;
        end else if (!at_limit) begin
          hold_d = hold_q + HW'(1);
        end
      end
    endcase
  end

  always_comb begin
    grant     = grant_q;
    grant_idx = idx_q;
    busy      = busy_q;
    timeout   = to_q;
  end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Bench for rr_ring_arbiter: directed scenarios plus random requests,
// checked against a behavioural owner/age/priority model.
module tb_rr_ring_arbiter;

  localparam int W  = 4;
  localparam int MH = 4;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req;
  logic [W-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          busy;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  int   m_owner;
  int   m_prio;
  int   m_age;
  logic m_to;

  always #5 clk = ~clk;

  rr_ring_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input logic [W-1:0] r, input int start);
    for (int i = 0; i < W; i++)
      if (r[(start + i) % W]) return (start + i) % W;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_age   = 0;
    m_to    = 1'b0;
  endtask

  // Owner index, cycles owned so far, and the highest-priority index.
  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0] rest;
    m_to = 1'b0;
    if (m_owner < 0) begin
      m_owner = first_from(r, m_prio);
      m_age   = 1;
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_prio  = (m_owner + 1) % W;
        m_owner = -1;
      end else if (m_age >= MH && rest != 0) begin
        m_prio  = (m_owner + 1) % W;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [W-1:0]  eg;
    logic [IW-1:0] ei;
    eg = '0;
    ei = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ei = IW'(m_owner);
    end
    chk({ph, ".grant"},   32'(grant),     32'(eg));
    chk({ph, ".idx"},     32'(grant_idx), 32'(ei));
    chk({ph, ".busy"},    32'(busy),      32'(m_owner >= 0));
    chk({ph, ".timeout"}, 32'(timeout),   32'(m_to));
  endtask

  task automatic cyc(input logic [W-1:0] r, input string ph);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_all(ph);
  endtask

  logic [W-1:0] s1 [14] = '{
    4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
    4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
    4'b0001, 4'b0001, 4'b0001, 4'b0001
  };

  initial begin
    logic [W-1:0] r;
    rst = 1'b0;
    req = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("rst");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cyc(4'b0101, "s1");
      chk("s1.seq", 32'(grant), 32'(s1[i]));
      chk("s1.to", 32'(timeout), 32'(i == 4 || i == 9));
    end
    cyc(4'b0000, "s1.end");

    for (int i = 0; i < 21; i++) begin
      cyc(4'b0010, "s2");
      chk("s2.grant", 32'(grant), 32'(4'b0010));
    end
    cyc(4'b0000, "s2.rel");
    chk("s2.rel0", 32'(grant), 32'(0));
    cyc(4'b0000, "s2.idle");

    for (int i = 0; i < 15; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_age >= 2) r[m_owner] = 1'b0;
      cyc(r, "s3");
    end

    for (int i = 0; i < 10 && m_owner != 2; i++)
      cyc(4'b0100, "wrap.get");
    chk("wrap.got", 32'(grant), 32'(4'b0100));
    cyc(4'b0000, "wrap.rel");
    cyc(4'b1001, "wrap.hi");
    chk("wrap.hi.g", 32'(grant), 32'(4'b1000));
    chk("wrap.hi.i", 32'(grant_idx), 32'(3));
    cyc(4'b0001, "wrap.rel2");
    cyc(4'b1011, "wrap.lo");
    chk("wrap.lo.g", 32'(grant), 32'(4'b0001));
    cyc(4'b0000, "wrap.end");

    cyc(4'b0011, "s5");
    chk("s5.first", 32'(grant), 32'(4'b0010));
    repeat (3) cyc(4'b0011, "s5.hold");
    cyc(4'b0001, "s5.drop");
    chk("s5.drop.g", 32'(grant), 32'(0));
    chk("s5.drop.to", 32'(timeout), 32'(0));
    cyc(4'b0001, "s5.next");
    chk("s5.next.g", 32'(grant), 32'(4'b0001));

    cyc(4'b0001, "ar.pre");
    #2;
    rst = 1'b0;
    #1;
    chk("ar.grant", 32'(grant), 32'(0));
    chk("ar.busy", 32'(busy), 32'(0));
    chk("ar.idx", 32'(grant_idx), 32'(0));
    chk("ar.to", 32'(timeout), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(4'b1000, "ar.post");
    chk("ar.post.g", 32'(grant), 32'(4'b1000));
    chk("ar.post.i", 32'(grant_idx), 32'(3));

    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = W'($urandom_range(0, 15));
      cyc(r, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
